// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_port_arbiter
// Two-port arbiter for a shared single-port RAM. Port A has priority, and a
// burst limiter caps how long B can be starved. Define RAM_ARB_RR_EN to use
// round-robin arbitration instead.
// Rev    : 1.0
// ============================================================================
module ram_port_arbiter #(
   parameter int g_RAM_WIDTH = 9,
   parameter int g_RAM_ADDR  = 11,
   parameter int g_MAX_BURST = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_a_req,
   input  logic                   i_a_we,
   input  logic [g_RAM_ADDR-1:0]  i_a_addr,
   input  logic [g_RAM_WIDTH-1:0] i_a_wdata,
   output logic                   o_a_gnt,
   output logic                   o_a_rvalid,
   output logic [g_RAM_WIDTH-1:0] o_a_rdata,
   input  logic                   i_b_req,
   input  logic                   i_b_we,
   input  logic [g_RAM_ADDR-1:0]  i_b_addr,
   input  logic [g_RAM_WIDTH-1:0] i_b_wdata,
   output logic                   o_b_gnt,
   output logic                   o_b_rvalid,
   output logic [g_RAM_WIDTH-1:0] o_b_rdata,
   output logic                   o_ram_en,
   output logic                   o_ram_we,
   output logic [g_RAM_ADDR-1:0]  o_ram_addr,
   output logic [g_RAM_WIDTH-1:0] o_ram_data,
   input  logic [g_RAM_WIDTH-1:0] i_ram_data
);

   logic                   sel_a, sel_b;
   logic                   a_gnt_d, a_gnt_q, b_gnt_d, b_gnt_q;
   logic                   ram_en_d, ram_en_q, ram_we_d, ram_we_q;
   logic [g_RAM_ADDR-1:0]  ram_addr_d, ram_addr_q;
   logic [g_RAM_WIDTH-1:0] ram_data_d, ram_data_q;
   logic                   tag1_v_d, tag1_v_q, tag1_p_d, tag1_p_q;
   logic                   tag2_v_d, tag2_v_q, tag2_p_d, tag2_p_q;
   logic                   a_rvalid_d, a_rvalid_q, b_rvalid_d, b_rvalid_q;
   logic [g_RAM_WIDTH-1:0] a_rdata_d, a_rdata_q, b_rdata_d, b_rdata_q;

`ifdef RAM_ARB_RR_EN
   logic last_b_d, last_b_q;
`else
   localparam logic [3:0] c_MAX_BURST = 4'(g_MAX_BURST);
   logic [3:0] burst_d, burst_q;
`endif

   always_comb begin
      sel_a = i_a_req;
      sel_b = i_b_req;
      if (i_a_req && i_b_req) begin
`ifdef RAM_ARB_RR_EN
         sel_a = last_b_q;
`else
         sel_a = (burst_q != c_MAX_BURST);
`endif
         sel_b = !sel_a;
      end

      a_gnt_d    = sel_a;
      b_gnt_d    = sel_b;
      ram_en_d   = sel_a | sel_b;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      if (sel_a) begin
         ram_we_d   = i_a_we;
         ram_addr_d = i_a_addr;
         ram_data_d = i_a_wdata;
      end else if (sel_b) begin
         ram_we_d   = i_b_we;
         ram_addr_d = i_b_addr;
         ram_data_d = i_b_wdata;
      end

      // Tag {valid, port} follows each read so its data returns to the issuer
      tag1_v_d   = (sel_a && !i_a_we) || (sel_b && !i_b_we);
      tag1_p_d   = sel_b;
      tag2_v_d   = tag1_v_q;
      tag2_p_d   = tag1_p_q;
      a_rvalid_d = tag2_v_q && !tag2_p_q;
      b_rvalid_d = tag2_v_q && tag2_p_q;
      a_rdata_d  = a_rvalid_d ? i_ram_data : a_rdata_q;
      b_rdata_d  = b_rvalid_d ? i_ram_data : b_rdata_q;

`ifdef RAM_ARB_RR_EN
      last_b_d = last_b_q;
      if (sel_b)      last_b_d = 1'b1;
      else if (sel_a) last_b_d = 1'b0;
`else
      burst_d = burst_q;
      if (!i_b_req || sel_b)                 burst_d = 4'd0;
      else if (sel_a && burst_q != c_MAX_BURST) burst_d = burst_q + 4'd1;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         a_gnt_q    <= 1'b0;
         b_gnt_q    <= 1'b0;
         ram_en_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         tag1_v_q   <= 1'b0;
         tag1_p_q   <= 1'b0;
         tag2_v_q   <= 1'b0;
         tag2_p_q   <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
`ifdef RAM_ARB_RR_EN
         last_b_q   <= 1'b1;
`else
         burst_q    <= 4'd0;
`endif
      end else begin
         a_gnt_q    <= a_gnt_d;
         b_gnt_q    <= b_gnt_d;
         ram_en_q   <= ram_en_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         tag1_v_q   <= tag1_v_d;
         tag1_p_q   <= tag1_p_d;
         tag2_v_q   <= tag2_v_d;
         tag2_p_q   <= tag2_p_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
`ifdef RAM_ARB_RR_EN
         last_b_q   <= last_b_d;
`else
         burst_q    <= burst_d;
`endif
      end
   end

   assign o_a_gnt    = a_gnt_q;
   assign o_b_gnt    = b_gnt_q;
   assign o_a_rvalid = a_rvalid_q;
   assign o_b_rvalid = b_rvalid_q;
   assign o_a_rdata  = a_rdata_q;
   assign o_b_rdata  = b_rdata_q;
   assign o_ram_en   = ram_en_q;
   assign o_ram_we   = ram_we_q;
   assign o_ram_addr = ram_addr_q;
   assign o_ram_data = ram_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_port_arbiter
// Directed self-checking bench for ram_port_arbiter with a behavioural RAM.
// Rev    : 1.0
// ============================================================================
module tb_ram_port_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_a_req, i_a_we, i_b_req, i_b_we;
   logic [10:0] i_a_addr, i_b_addr;
   logic [8:0]  i_a_wdata, i_b_wdata;
   logic        o_a_gnt, o_a_rvalid, o_b_gnt, o_b_rvalid;
   logic [8:0]  o_a_rdata, o_b_rdata;
   logic        o_ram_en, o_ram_we;
   logic [10:0] o_ram_addr;
   logic [8:0]  o_ram_data;
   logic [8:0]  i_ram_data;

   int total = 0;
   int bad   = 0;

   logic [8:0] mem [0:2047];

   always #5 i_clk = ~i_clk;

   ram_port_arbiter #(.g_RAM_WIDTH(9), .g_RAM_ADDR(11), .g_MAX_BURST(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_a_req(i_a_req), .i_a_we(i_a_we), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata),
      .o_a_gnt(o_a_gnt), .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata),
      .i_b_req(i_b_req), .i_b_we(i_b_we), .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata),
      .o_b_gnt(o_b_gnt), .o_b_rvalid(o_b_rvalid), .o_b_rdata(o_b_rdata),
      .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
      .o_ram_data(o_ram_data), .i_ram_data(i_ram_data)
   );

   // Synchronous single-port RAM: read data valid the cycle after the access
   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 9'h000;
      i_ram_data = 9'h000;
   end
   always @(posedge i_clk) begin
      if (o_ram_en) begin
         if (o_ram_we) mem[o_ram_addr] <= o_ram_data;
         else          i_ram_data <= mem[o_ram_addr];
      end
   end

   task automatic tick;
      @(negedge i_clk);
   endtask

   task automatic do_write(input bit port_b, input logic [10:0] addr, input logic [8:0] data);
      if (port_b) begin
         i_b_req = 1'b1; i_b_we = 1'b1; i_b_addr = addr; i_b_wdata = data;
      end else begin
         i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = addr; i_a_wdata = data;
      end
      tick();
      i_a_req = 1'b0; i_b_req = 1'b0;
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = 11'h055; i_a_wdata = 9'h0AA;
      i_b_req = 1'b1; i_b_we = 1'b0; i_b_addr = 11'h066; i_b_wdata = 9'h0BB;
      tick(); tick(); tick();
      total++;
      if ({o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_ram_en, o_ram_we} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_ram_en, o_ram_we});
      end
      total++;
      if (o_ram_addr !== 11'h000 || o_ram_data !== 9'h000) begin
         bad++;
         $display("FAIL reset_bus: got addr=%h data=%h expected 000/000", o_ram_addr, o_ram_data);
      end
      total++;
      if (o_a_rdata !== 9'h000 || o_b_rdata !== 9'h000) begin
         bad++;
         $display("FAIL reset_rdata: got a=%h b=%h expected 000/000", o_a_rdata, o_b_rdata);
      end
      i_a_req = 1'b0; i_b_req = 1'b0;
      i_rst = 1'b0;
      tick();
   endtask

   task automatic test_write_read;
      i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = 11'h010; i_a_wdata = 9'h1A5;
      tick();
      total++;
      if (o_a_gnt !== 1'b1 || o_ram_en !== 1'b1 || o_ram_we !== 1'b1 ||
          o_ram_addr !== 11'h010 || o_ram_data !== 9'h1A5) begin
         bad++;
         $display("FAIL wr_cmd: got gnt=%b en=%b we=%b addr=%h data=%h expected 1 1 1 010 1a5",
                  o_a_gnt, o_ram_en, o_ram_we, o_ram_addr, o_ram_data);
      end
      i_a_we = 1'b0; i_a_wdata = 9'h000;
      tick();
      total++;
      if (o_a_gnt !== 1'b1 || o_ram_en !== 1'b1 || o_ram_we !== 1'b0 || o_ram_addr !== 11'h010) begin
         bad++;
         $display("FAIL rd_cmd: got gnt=%b en=%b we=%b addr=%h expected 1 1 0 010",
                  o_a_gnt, o_ram_en, o_ram_we, o_ram_addr);
      end
      i_a_req = 1'b0;
      tick();
      total++;
      if (o_a_rvalid !== 1'b0 || o_b_rvalid !== 1'b0 || o_ram_en !== 1'b0 || o_ram_we !== 1'b0) begin
         bad++;
         $display("FAIL rd_k1: got a_rv=%b b_rv=%b en=%b we=%b expected 0 0 0 0",
                  o_a_rvalid, o_b_rvalid, o_ram_en, o_ram_we);
      end
      tick();
      total++;
      if (o_a_rvalid !== 1'b1 || o_a_rdata !== 9'h1A5 || o_b_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL rd_k2: got a_rv=%b a_rdata=%h b_rv=%b expected 1 1a5 0",
                  o_a_rvalid, o_a_rdata, o_b_rvalid);
      end
      tick();
      total++;
      if (o_a_rvalid !== 1'b0 || o_a_rdata !== 9'h1A5) begin
         bad++;
         $display("FAIL rd_k3: got a_rv=%b a_rdata=%h expected 0 1a5", o_a_rvalid, o_a_rdata);
      end
   endtask

   task automatic test_burst_limit;
      bit exp_a [0:11];
      i_rst = 1'b1; tick(); i_rst = 1'b0;
      i_a_req = 1'b1; i_a_we = 1'b0; i_a_addr = 11'h010;
      i_b_req = 1'b1; i_b_we = 1'b0; i_b_addr = 11'h020;
      for (int i = 0; i < 12; i++) begin
         exp_a[i] = (i % 5) < 4;
         tick();
         total++;
         if (o_a_gnt !== exp_a[i] || o_b_gnt !== !exp_a[i]) begin
            bad++;
            $display("FAIL burst_gnt[%0d]: got a=%b b=%b expected a=%b b=%b",
                     i, o_a_gnt, o_b_gnt, exp_a[i], !exp_a[i]);
         end
         if (i >= 2) begin
            total++;
            if (o_a_rvalid !== exp_a[i-2] || o_b_rvalid !== !exp_a[i-2]) begin
               bad++;
               $display("FAIL burst_rvalid[%0d]: got a=%b b=%b expected a=%b b=%b",
                        i, o_a_rvalid, o_b_rvalid, exp_a[i-2], !exp_a[i-2]);
            end
         end
      end
      i_a_req = 1'b0; i_b_req = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_interleaved;
      do_write(1'b1, 11'h7FF, 9'h0FF);
      do_write(1'b0, 11'h000, 9'h155);
      tick();
      i_b_req = 1'b1; i_b_we = 1'b0; i_b_addr = 11'h7FF;
      tick();
      total++;
      if (o_b_gnt !== 1'b1 || o_a_gnt !== 1'b0 || o_ram_addr !== 11'h7FF) begin
         bad++;
         $display("FAIL il_bgnt: got b=%b a=%b addr=%h expected 1 0 7ff", o_b_gnt, o_a_gnt, o_ram_addr);
      end
      i_b_req = 1'b0;
      i_a_req = 1'b1; i_a_we = 1'b0; i_a_addr = 11'h000;
      tick();
      total++;
      if (o_a_gnt !== 1'b1 || o_b_gnt !== 1'b0 || o_ram_addr !== 11'h000) begin
         bad++;
         $display("FAIL il_agnt: got a=%b b=%b addr=%h expected 1 0 000", o_a_gnt, o_b_gnt, o_ram_addr);
      end
      i_a_req = 1'b0;
      tick();
      total++;
      if (o_b_rvalid !== 1'b1 || o_b_rdata !== 9'h0FF || o_a_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL il_k2: got b_rv=%b b_rdata=%h a_rv=%b expected 1 0ff 0",
                  o_b_rvalid, o_b_rdata, o_a_rvalid);
      end
      tick();
      total++;
      if (o_a_rvalid !== 1'b1 || o_a_rdata !== 9'h155 || o_b_rvalid !== 1'b0 || o_b_rdata !== 9'h0FF) begin
         bad++;
         $display("FAIL il_k3: got a_rv=%b a_rdata=%h b_rv=%b b_rdata=%h expected 1 155 0 0ff",
                  o_a_rvalid, o_a_rdata, o_b_rvalid, o_b_rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid_read;
      i_a_req = 1'b1; i_a_we = 1'b0; i_a_addr = 11'h010;
      tick();
      total++;
      if (o_a_gnt !== 1'b1) begin
         bad++;
         $display("FAIL mr_gnt: got %b expected 1", o_a_gnt);
      end
      i_a_req = 1'b0;
      tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_ram_en, o_ram_we} !== 6'b0 ||
             o_ram_addr !== 11'h000 || o_ram_data !== 9'h000 ||
             o_a_rdata !== 9'h000 || o_b_rdata !== 9'h000) begin
            bad++;
            $display("FAIL mr_after[%0d]: got ctl=%b addr=%h data=%h ard=%h brd=%h expected all 0",
                     i, {o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_ram_en, o_ram_we},
                     o_ram_addr, o_ram_data, o_a_rdata, o_b_rdata);
         end
         tick();
      end
   endtask

   task automatic test_idle;
      do_write(1'b0, 11'h123, 9'h0AB);
      total++;
      if (o_ram_en !== 1'b1 || o_ram_we !== 1'b1 || o_ram_addr !== 11'h123) begin
         bad++;
         $display("FAIL idle_wr: got en=%b we=%b addr=%h expected 1 1 123", o_ram_en, o_ram_we, o_ram_addr);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (o_ram_en !== 1'b0 || o_ram_we !== 1'b0 || o_ram_addr !== 11'h123 || o_ram_data !== 9'h0AB) begin
            bad++;
            $display("FAIL idle[%0d]: got en=%b we=%b addr=%h data=%h expected 0 0 123 0ab",
                     i, o_ram_en, o_ram_we, o_ram_addr, o_ram_data);
         end
      end
   endtask

   initial begin
      i_rst = 1'b1;
      i_a_req = 1'b0; i_a_we = 1'b0; i_a_addr = '0; i_a_wdata = '0;
      i_b_req = 1'b0; i_b_we = 1'b0; i_b_addr = '0; i_b_wdata = '0;
      test_reset();
      test_write_read();
      test_burst_limit();
      test_interleaved();
      test_reset_mid_read();
      test_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
